// File: rtl/int_ack_sequencer.sv
// Single-level interrupt acknowledge sequencer: latches one-hot grants, applies a mask,
// and runs the irq/ack/eoi handshake with the CPU, issuing VEC_BASE+source as the vector.
module int_ack_sequencer #(
    parameter logic [7:0] VEC_BASE    = 8'h20,
    parameter logic [7:0] ACK_TIMEOUT = 8'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] grant,
    input  logic       mask_wr,
    input  logic [3:0] mask_in,
    input  logic       ack,
    input  logic       eoi,
    output logic       irq,
    output logic [7:0] vector,
    output logic       vec_valid,
    output logic [3:0] in_service,
    output logic [3:0] mask,
    output logic       timeout_err
);

    // Handshake: irq stays high in REQ until ack (taken on that edge), the mask
    // withdraws the request, or the ack timeout expires. eoi is only seen in SERVICE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] pending;
    logic [1:0] sel;
    logic [7:0] counter;

    logic [3:0] mask_next;
    logic [3:0] avail;
    logic [3:0] sel_onehot;
    logic [3:0] pending_clr;
    logic [1:0] low_idx;
    logic       ack_take;

    assign mask_next   = mask_wr ? mask_in : mask;
    assign avail       = pending & ~mask;
    assign sel_onehot  = 4'b0001 << sel;
    assign ack_take    = (state == REQ) && ack;
    assign pending_clr = ack_take ? sel_onehot : 4'b0000;
    assign irq         = (state == REQ);

    // Lowest set index wins among unmasked pending sources.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (avail[i]) low_idx = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= 4'b0000;
            mask        <= 4'b0000;
            sel         <= 2'd0;
            counter     <= 8'd0;
            vector      <= 8'd0;
            vec_valid   <= 1'b0;
            in_service  <= 4'b0000;
            timeout_err <= 1'b0;
        end else begin
            vec_valid   <= 1'b0;
            timeout_err <= 1'b0;
            mask        <= mask_next;
            pending     <= (pending & ~pending_clr) | (grant & ~mask_next);
            case (state)
                IDLE: begin
                    if (|avail) begin
                        sel     <= low_idx;
                        counter <= 8'd0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        vector     <= VEC_BASE + {6'd0, sel};
                        vec_valid  <= 1'b1;
                        in_service <= sel_onehot;
                        state      <= SERVICE;
                    end else if (mask[sel]) begin
                        state <= IDLE;
                    end else if ((ACK_TIMEOUT != 8'd0) && (counter == ACK_TIMEOUT - 8'd1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else if (counter != 8'hFF) begin
                        counter <= counter + 8'd1;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        in_service <= 4'b0000;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Bench for int_ack_sequencer: directed scenarios plus randomized traffic checked against
// a source-indexed behavioural model (who is asking, who is served, what is pending).
module tb_int_ack_sequencer;

    localparam logic [7:0] VB    = 8'h20;
    localparam int         T_OUT = 4;

    logic       clk;
    logic       rst;
    logic [3:0] grant;
    logic       mask_wr;
    logic [3:0] mask_in;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [7:0] vector;
    logic       vec_valid;
    logic [3:0] in_service;
    logic [3:0] mask;
    logic       timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: m_ask = source currently asking the CPU (-1 none), m_serv = source being served.
    logic [3:0] m_pend;
    logic [3:0] m_msk;
    int         m_ask;
    int         m_serv;
    int         m_wait;
    logic [7:0] m_vec;
    logic       m_vv;
    logic       m_to;

    int_ack_sequencer #(.VEC_BASE(VB), .ACK_TIMEOUT(8'(T_OUT))) dut (
        .clk(clk), .rst(rst), .grant(grant), .mask_wr(mask_wr), .mask_in(mask_in),
        .ack(ack), .eoi(eoi), .irq(irq), .vector(vector), .vec_valid(vec_valid),
        .in_service(in_service), .mask(mask), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_step(input logic [3:0] g, input logic mw, input logic [3:0] mi,
                              input logic a, input logic e, input logic r);
        logic [3:0] new_msk;
        int clr;
        int pick;
        if (r) begin
            m_pend = 4'b0; m_msk = 4'b0; m_ask = -1; m_serv = -1; m_wait = 0;
            m_vec = 8'd0; m_vv = 1'b0; m_to = 1'b0;
            return;
        end
        m_vv = 1'b0;
        m_to = 1'b0;
        clr  = -1;
        new_msk = mw ? mi : m_msk;
        if (m_ask >= 0) begin
            if (a) begin
                m_vec = 8'(VB + 8'(m_ask)); m_vv = 1'b1; m_serv = m_ask; clr = m_ask; m_ask = -1;
            end else if (m_msk[m_ask]) begin
                m_ask = -1;
            end else if (T_OUT != 0 && m_wait == T_OUT - 1) begin
                m_to = 1'b1; m_ask = -1;
            end else if (m_wait < 255) begin
                m_wait++;
            end
        end else if (m_serv >= 0) begin
            if (e) m_serv = -1;
        end else begin
            pick = -1;
            for (int i = 0; i < 4; i++) if (m_pend[i] && !m_msk[i] && pick < 0) pick = i;
            if (pick >= 0) begin
                m_ask = pick; m_wait = 0;
            end
        end
        if (clr >= 0) m_pend[clr] = 1'b0;
        for (int i = 0; i < 4; i++) if (g[i] && !new_msk[i]) m_pend[i] = 1'b1;
        m_msk = new_msk;
    endtask

    // Drives one cycle of inputs, advances the model at the edge, returns at the falling edge.
    task automatic tick(input logic [3:0] g, input logic mw, input logic [3:0] mi,
                        input logic a, input logic e, input logic r);
        grant = g; mask_wr = mw; mask_in = mi; ack = a; eoi = e; rst = r;
        @(posedge clk);
        model_step(g, mw, mi, a, e, r);
        @(negedge clk);
        grant = 4'b0; mask_wr = 1'b0; mask_in = 4'b0; ack = 1'b0; eoi = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
        n_checks++; if (vector !== 8'h00) $display("FAIL reset_vector: got %h want 00", vector); else n_pass++;
        n_checks++; if (vec_valid !== 1'b0) $display("FAIL reset_vec_valid: got %b want 0", vec_valid); else n_pass++;
        n_checks++; if (in_service !== 4'b0) $display("FAIL reset_in_service: got %b want 0000", in_service); else n_pass++;
        n_checks++; if (mask !== 4'b0) $display("FAIL reset_mask: got %b want 0000", mask); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_err); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b0) $display("FAIL reset_idle_irq: got %b want 0", irq); else n_pass++;
    endtask

    task automatic test_single();
        tick(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b0) $display("FAIL single_latency: got irq %b want 0", irq); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b1) $display("FAIL single_irq: got %b want 1", irq); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (vector !== 8'h22) $display("FAIL single_vector: got %h want 22", vector); else n_pass++;
        n_checks++; if (vec_valid !== 1'b1) $display("FAIL single_vec_valid: got %b want 1", vec_valid); else n_pass++;
        n_checks++; if (in_service !== 4'b0100) $display("FAIL single_in_service: got %b want 0100", in_service); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL single_irq_drop: got %b want 0", irq); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (vec_valid !== 1'b0) $display("FAIL single_vv_pulse: got %b want 0", vec_valid); else n_pass++;
        n_checks++; if (vector !== 8'h22) $display("FAIL single_vector_hold: got %h want 22", vector); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (in_service !== 4'b0) $display("FAIL single_eoi: got %b want 0000", in_service); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b0) $display("FAIL single_idle: got irq %b want 0", irq); else n_pass++;
    endtask

    task automatic test_multi();
        logic [7:0] exp_v [2];
        int w;
        exp_v[0] = 8'h21;
        exp_v[1] = 8'h23;
        // Occupy the CPU with source 0 so both new grants are pending when it frees up.
        tick(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0, 1'b0, 4'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (in_service !== 4'b0001) $display("FAIL multi_first: got %b want 0001", in_service); else n_pass++;
        tick(4'b1000, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0010, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b0) $display("FAIL multi_no_nest: got irq %b want 0", irq); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            w = 0;
            while (irq !== 1'b1 && w < 5) begin
                tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
                w++;
            end
            n_checks++; if (irq !== 1'b1) $display("FAIL multi_irq_wait[%0d]: got %b want 1", k, irq); else n_pass++;
            n_checks++; if (in_service !== 4'b0) $display("FAIL multi_irq_while_serv[%0d]: got %b want 0000", k, in_service); else n_pass++;
            tick(4'b0, 1'b0, 4'b0, 1'b1, 1'b0, 1'b0);
            n_checks++; if (vector !== exp_v[k]) $display("FAIL multi_vector[%0d]: got %h want %h", k, vector, exp_v[k]); else n_pass++;
            tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_mask();
        tick(4'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        n_checks++; if (mask !== 4'b0001) $display("FAIL mask_write: got %b want 0001", mask); else n_pass++;
        tick(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
            n_checks++; if (irq !== 1'b0) $display("FAIL mask_blocked[%0d]: got irq %b want 0", i, irq); else n_pass++;
        end
        tick(4'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
            n_checks++; if (irq !== 1'b0) $display("FAIL mask_not_latched[%0d]: got irq %b want 0", i, irq); else n_pass++;
        end
        tick(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b1) $display("FAIL mask_unmasked_irq: got %b want 1", irq); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (vector !== 8'h20) $display("FAIL mask_vector: got %h want 20", vector); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        tick(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < T_OUT; i++) begin
            tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
            n_checks++; if (irq !== 1'b1 || timeout_err !== 1'b0) $display("FAIL timeout_wait[%0d]: got irq %b err %b want 1 0", i, irq, timeout_err); else n_pass++;
        end
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b0 || timeout_err !== 1'b1) $display("FAIL timeout_fire: got irq %b err %b want 0 1", irq, timeout_err); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b1 || timeout_err !== 1'b0) $display("FAIL timeout_retry: got irq %b err %b want 1 0", irq, timeout_err); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (vector !== 8'h20) $display("FAIL timeout_vector: got %h want 20", vector); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_simultaneous();
        tick(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
        n_checks++; if (vec_valid !== 1'b1 || vector !== 8'h22) $display("FAIL simul_ack_wins: got vv %b vec %h want 1 22", vec_valid, vector); else n_pass++;
        n_checks++; if (in_service !== 4'b0100) $display("FAIL simul_in_service: got %b want 0100", in_service); else n_pass++;
        n_checks++; if (mask !== 4'b0100) $display("FAIL simul_mask: got %b want 0100", mask); else n_pass++;
        tick(4'b0010, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if ({irq, vector, vec_valid, in_service, mask, timeout_err} !== 19'd0)
            $display("FAIL simul_reset_outputs: got irq %b vec %h vv %b is %b mask %b to %b want all 0",
                     irq, vector, vec_valid, in_service, mask, timeout_err);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
            n_checks++; if (irq !== 1'b0) $display("FAIL simul_pending_cleared[%0d]: got irq %b want 0", i, irq); else n_pass++;
        end
    endtask

    task automatic test_reentry();
        tick(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0, 1'b0, 4'b0, 1'b1, 1'b0, 1'b0);
        tick(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b0 || in_service !== 4'b0100) $display("FAIL reentry_serv: got irq %b is %b want 0 0100", irq, in_service); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (irq !== 1'b0 || in_service !== 4'b0) $display("FAIL reentry_eoi: got irq %b is %b want 0 0000", irq, in_service); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b1) $display("FAIL reentry_irq: got %b want 1", irq); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (vector !== 8'h22 || vec_valid !== 1'b1) $display("FAIL reentry_vector: got %h vv %b want 22 1", vector, vec_valid); else n_pass++;
        tick(4'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] g, mi;
        logic       mw, a, e, r;
        logic       exp_irq;
        logic [3:0] exp_is;
        for (int c = 0; c < 800; c++) begin
            g  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            mw = ($urandom_range(0, 19) == 0);
            mi = 4'($urandom) & 4'($urandom);
            a  = ($urandom_range(0, 3) == 0);
            e  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 249) == 0);
            tick(g, mw, mi, a, e, r);
            exp_irq = (m_ask >= 0);
            exp_is  = (m_serv >= 0) ? 4'(4'b0001 << m_serv) : 4'b0000;
            n_checks++; if (irq !== exp_irq) $display("FAIL rand_irq@%0d: got %b want %b", c, irq, exp_irq); else n_pass++;
            n_checks++; if (vector !== m_vec) $display("FAIL rand_vector@%0d: got %h want %h", c, vector, m_vec); else n_pass++;
            n_checks++; if (vec_valid !== m_vv) $display("FAIL rand_vec_valid@%0d: got %b want %b", c, vec_valid, m_vv); else n_pass++;
            n_checks++; if (in_service !== exp_is) $display("FAIL rand_in_service@%0d: got %b want %b", c, in_service, exp_is); else n_pass++;
            n_checks++; if (mask !== m_msk) $display("FAIL rand_mask@%0d: got %b want %b", c, mask, m_msk); else n_pass++;
            n_checks++; if (timeout_err !== m_to) $display("FAIL rand_timeout@%0d: got %b want %b", c, timeout_err, m_to); else n_pass++;
            n_checks++; if ((irq && (in_service != 4'b0)) || (vec_valid && timeout_err))
                $display("FAIL rand_exclusive@%0d: got irq %b is %b vv %b to %b", c, irq, in_service, vec_valid, timeout_err);
            else n_pass++;
        end
    endtask

    initial begin
        grant = 4'b0; mask_wr = 1'b0; mask_in = 4'b0; ack = 1'b0; eoi = 1'b0; rst = 1'b1;
        m_pend = 4'b0; m_msk = 4'b0; m_ask = -1; m_serv = -1; m_wait = 0;
        m_vec = 8'd0; m_vv = 1'b0; m_to = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_mask();
        test_timeout();
        test_simultaneous();
        test_reentry();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
